// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types for the AXI-Stream packet FIFO: write FSM encoding and
// the bit layout of one stored beat {tdata, tkeep, tlast, tuser}.
package axis_pkt_fifo_pkg;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_FRAME = 2'd1,
      WR_DROP  = 2'd2
   } wr_state_e;

   localparam int USER_OFS = 0;

   function automatic int last_ofs(input int user_w);
      return user_w;
   endfunction

   function automatic int keep_ofs(input int user_w);
      return user_w + 1;
   endfunction

   function automatic int data_ofs(input int user_w, input int keep_w);
      return user_w + 1 + keep_w;
   endfunction

   function automatic int word_width(input int data_w, input int keep_w, input int user_w);
      return data_w + keep_w + 1 + user_w;
   endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module axis_pkt_fifo_ram
   import axis_pkt_fifo_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [WIDTH-1:0]      rd_data_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   // Read register only advances on rd_en so a stalled word stays put.
   always_ff @(posedge clk) begin
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO: store-and-forward with bad/oversize frame drop
// (FRAME_FIFO=1) or plain word FIFO (FRAME_FIFO=0).
module axis_pkt_fifo
   import axis_pkt_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int DEPTH      = 512,
   parameter int USER_WIDTH = 1,
   parameter int FRAME_FIFO = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [USER_WIDTH-1:0]   s_axis_tuser,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [USER_WIDTH-1:0]   m_axis_tuser,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    status_overflow,
   output logic                    status_bad_frame
);

   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = AW + 1;
   localparam int SW   = word_width(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH);
   localparam int LOFS = last_ofs(USER_WIDTH);
   localparam int KOFS = keep_ofs(USER_WIDTH);
   localparam int DOFS = data_ofs(USER_WIDTH, KEEP_WIDTH);
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   logic [PW-1:0] wr_cur_q, wr_commit_q, rd_ptr_q, out_ptr_q;
   logic [PW-1:0] wr_cur_inc, wr_cur_d, out_ptr_d;
   wr_state_e     state_q;
   logic          ready_q, ovf_q, bad_q;
   logic [1:0]    vld_q;
   logic [SW-1:0] wr_word, rd_word, out_q;
   logic          accept, wr_en, rd_en, s2_load, out_fire, cur_full;

   assign s_axis_tready = ready_q & ~rst;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign cur_full      = (wr_cur_q - rd_ptr_q) == DEPTH_P;
   assign wr_en         = accept & ((FRAME_FIFO == 0) | ((state_q != WR_DROP) & ~cur_full));
   assign wr_cur_inc    = wr_cur_q + PW'(1);
   assign wr_cur_d      = wr_en ? wr_cur_inc : wr_cur_q;
   assign wr_word       = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

   assign out_fire  = m_axis_tvalid & m_axis_tready;
   assign out_ptr_d = out_fire ? out_ptr_q + PW'(1) : out_ptr_q;
   assign s2_load   = ~vld_q[1] | m_axis_tready;
   assign rd_en     = (rd_ptr_q != wr_commit_q) & (~vld_q[0] | s2_load);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cur_q    <= '0;
         wr_commit_q <= '0;
         state_q     <= WR_IDLE;
         ready_q     <= 1'b1;
         ovf_q       <= 1'b0;
         bad_q       <= 1'b0;
      end else begin
         ovf_q <= 1'b0;
         bad_q <= 1'b0;
         if (FRAME_FIFO == 0) begin
            if (wr_en) begin
               wr_cur_q    <= wr_cur_inc;
               wr_commit_q <= wr_cur_inc;
            end
            // Words in the output pipeline still count, so capacity is exactly DEPTH.
            ready_q <= (wr_cur_d - out_ptr_d) != DEPTH_P;
         end else if (accept) begin
            case (state_q)
               WR_DROP: begin
                  if (s_axis_tlast) begin
                     ovf_q   <= 1'b1;
                     state_q <= WR_IDLE;
                  end
               end
               default: begin
                  if (cur_full) begin
                     wr_cur_q <= wr_commit_q;
                     if (s_axis_tlast) begin
                        ovf_q   <= 1'b1;
                        state_q <= WR_IDLE;
                     end else begin
                        state_q <= WR_DROP;
                     end
                  end else if (s_axis_tlast) begin
                     state_q <= WR_IDLE;
                     if (s_axis_tuser[0]) begin
                        wr_cur_q <= wr_commit_q;
                        bad_q    <= 1'b1;
                     end else begin
                        wr_cur_q    <= wr_cur_inc;
                        wr_commit_q <= wr_cur_inc;
                     end
                  end else begin
                     wr_cur_q <= wr_cur_inc;
                     state_q  <= WR_FRAME;
                  end
               end
            endcase
         end
      end
   end

   // Two-stage read: RAM read register (vld_q[0]) feeding the output register (vld_q[1]).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q  <= '0;
         out_ptr_q <= '0;
         vld_q     <= '0;
      end else begin
         if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
         out_ptr_q <= out_ptr_d;
         if (rd_en)        vld_q[0] <= 1'b1;
         else if (s2_load) vld_q[0] <= 1'b0;
         if (s2_load)      vld_q[1] <= vld_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (s2_load && vld_q[0]) out_q <= rd_word;
   end

   axis_pkt_fifo_ram #(
      .WIDTH      (SW),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_cur_q[AW-1:0]),
      .wr_data_i (wr_word),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_data_o (rd_word)
   );

   assign m_axis_tvalid    = vld_q[1];
   assign m_axis_tdata     = out_q[DOFS +: DATA_WIDTH];
   assign m_axis_tkeep     = out_q[KOFS +: KEEP_WIDTH];
   assign m_axis_tlast     = out_q[LOFS];
   assign m_axis_tuser     = out_q[USER_OFS +: USER_WIDTH];
   assign occupancy        = wr_commit_q - rd_ptr_q;
   assign status_overflow  = ovf_q;
   assign status_bad_frame = bad_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: directed frame cases plus randomized traffic
// against a frame-level queue model; a second instance runs as a plain FIFO.
module tb_axis_pkt_fifo;

   localparam int DW = 64, KW = 8, UW = 1, DEPTH = 16, OW = 5;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [UW-1:0] user;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [DW-1:0] s_tdata = '0, m_tdata;
   logic [KW-1:0] s_tkeep = '0, m_tkeep;
   logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [UW-1:0] s_tuser = '0, m_tuser;
   logic          m_tvalid, m_tready = 1'b0, m_tlast;
   logic [OW-1:0] occ;
   logic          ovf, bad;

   logic [DW-1:0] p_s_tdata = '0, p_m_tdata;
   logic [KW-1:0] p_s_tkeep = '0, p_m_tkeep;
   logic          p_s_tvalid = 1'b0, p_s_tready, p_s_tlast = 1'b0;
   logic [UW-1:0] p_s_tuser = '0, p_m_tuser;
   logic          p_m_tvalid, p_m_tready = 1'b0, p_m_tlast;
   logic [OW-1:0] p_occ;
   logic          p_ovf, p_bad;

   always #5 clk = ~clk;

   axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .USER_WIDTH(UW), .FRAME_FIFO(1)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .occupancy(occ), .status_overflow(ovf), .status_bad_frame(bad)
   );

   axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .USER_WIDTH(UW), .FRAME_FIFO(0)) dut_plain (
      .clk(clk), .rst(rst),
      .s_axis_tdata(p_s_tdata), .s_axis_tkeep(p_s_tkeep), .s_axis_tvalid(p_s_tvalid),
      .s_axis_tready(p_s_tready), .s_axis_tlast(p_s_tlast), .s_axis_tuser(p_s_tuser),
      .m_axis_tdata(p_m_tdata), .m_axis_tkeep(p_m_tkeep), .m_axis_tvalid(p_m_tvalid),
      .m_axis_tready(p_m_tready), .m_axis_tlast(p_m_tlast), .m_axis_tuser(p_m_tuser),
      .occupancy(p_occ), .status_overflow(p_ovf), .status_bad_frame(p_bad)
   );

   int    checks = 0, failures = 0;
   beat_t exp_q[$];
   int    nbad = 0, novf = 0, occ_max = 0, exp_bad = 0;
   bit    mon_en = 0, stall_prev = 0, rand_rdy = 0;
   beat_t held;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard pop on handshake, hold-stable check while stalled.
   always @(negedge clk) begin
      beat_t cur;
      if (mon_en) begin
         cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
         if (int'(occ) > occ_max) occ_max = int'(occ);
         if (bad) nbad++;
         if (ovf) novf++;
         if (stall_prev) begin
            chk("stall_valid", m_tvalid, 1);
            chk("stall_hold", cur, held);
         end
         if (m_tvalid && m_tready) begin
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("out_beat", cur, exp_q.pop_front());
         end
         stall_prev = m_tvalid && !m_tready;
         held = cur;
      end else begin
         stall_prev = 0;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic fbeat(input beat_t b, input bit chk_rdy);
      int n;
      bit ok;
      s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last; s_tuser = b.user; s_tvalid = 1'b1;
      n = 0; ok = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = s_tready;
         if (chk_rdy) chk("s_tready_high", s_tready, 1);
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk("send_timeout", ok, 1);
      s_tvalid = 1'b0;
   endtask

   // Frame-level model: a frame is delivered whole unless flagged bad or longer than DEPTH.
   task automatic send_frame(input int len, input bit badf, input bit gaps, input bit seq, input logic [DW-1:0] base);
      beat_t b;
      bit    keep_it;
      keep_it = !badf && (len <= DEPTH);
      for (int i = 0; i < len; i++) begin
         b.data = seq ? base + DW'(i) : {$urandom(), $urandom()};
         b.keep = seq ? '1 : KW'($urandom());
         b.last = (i == len - 1);
         b.user = b.last ? UW'(badf) : UW'($urandom_range(0, 1));
         if (keep_it) exp_q.push_back(b);
         fbeat(b, 1);
         if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      end
      if (badf) exp_bad++;
   endtask

   task automatic pbeat(input logic [DW-1:0] d, input bit last, input bit user);
      int n;
      bit ok;
      p_s_tdata = d; p_s_tkeep = '1; p_s_tlast = last; p_s_tuser = UW'(user); p_s_tvalid = 1'b1;
      n = 0; ok = 0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = p_s_tready;
         @(posedge clk);
         #1;
         n++;
      end
      chk("p_accept", ok, 1);
      p_s_tvalid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int len;
      bit badf;
      beat_t b;

      // Reset state
      repeat (3) step();
      @(negedge clk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_occ", occ, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_p_s_tready", p_s_tready, 0);
      chk("rst_pulses", {ovf, bad}, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", s_tready, 1);
      chk("p_ready_after_rst", p_s_tready, 1);
      step();

      // Good 4-beat frame: latency, contiguity, occupancy peak
      m_tready = 1'b1; mon_en = 1; occ_max = 0;
      send_frame(4, 0, 0, 1, 64'h1);
      @(negedge clk); chk("lat_cycle1", m_tvalid, 0);
      @(negedge clk); chk("lat_cycle2", m_tvalid, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("contig_valid", m_tvalid, 1);
      end
      step();
      repeat (3) step();
      chk("occ_peak", occ_max, 4);
      chk("occ_drained", occ, 0);
      chk("good_all_out", exp_q.size(), 0);

      // Bad frame dropped, following good frame intact
      nbad = 0; exp_bad = 0;
      send_frame(3, 1, 0, 1, 64'h10);
      repeat (6) step();
      chk("bad_pulse_cnt", nbad, exp_bad);
      chk("bad_occ", occ, 0);
      send_frame(4, 0, 0, 1, 64'h100);
      repeat (8) step();
      chk("after_bad_out", exp_q.size(), 0);

      // Oversize frame dropped with one overflow pulse on its last beat
      novf = 0;
      send_frame(20, 0, 0, 1, 64'h200);
      chk("ovf_on_last", ovf, 1);
      chk("ovf_not_early", novf, 0);
      repeat (6) step();
      chk("ovf_pulse_cnt", novf, 1);
      chk("ovf_occ", occ, 0);
      chk("ovf_no_out", exp_q.size(), 0);
      chk("ovf_no_bad", nbad, 1);

      // Plain FIFO: 16 of 17 accepted while downstream stalls, then drained in order
      for (int i = 1; i <= 16; i++) pbeat(DW'(i), i == 8, i == 8);
      @(negedge clk);
      chk("p_full_ready", p_s_tready, 0);
      step();
      p_s_tdata = DW'(17); p_s_tvalid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("p_17th_rejected", p_s_tready, 0);
         step();
      end
      p_s_tvalid = 1'b0;
      p_m_tready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         n = 0;
         @(negedge clk);
         while (!p_m_tvalid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("p_out_valid", p_m_tvalid, 1);
         chk("p_out_data", p_m_tdata, DW'(k));
         if (k == 8) chk("p_out_user", {p_m_tlast, p_m_tuser}, 2'b11);
      end
      repeat (3) begin
         @(negedge clk);
         chk("p_no_extra", p_m_tvalid, 0);
      end
      step();

      // Random frames, random gaps, random downstream backpressure
      nbad = 0; novf = 0; exp_bad = 0;
      rand_rdy = 1;
      for (int f = 0; f < 100; f++) begin
         len  = $urandom_range(1, 6);
         badf = ($urandom_range(0, 7) == 0);
         n = 0;
         while (exp_q.size() + len > DEPTH && n < 500) begin
            step();
            n++;
         end
         if (n >= 500) chk("pace_timeout", exp_q.size() + len <= DEPTH, 1);
         send_frame(len, badf, 1, 0, '0);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_bad_cnt", nbad, exp_bad);
      chk("rand_no_ovf", novf, 0);
      rand_rdy = 0;
      step();
      m_tready = 1'b1;
      repeat (3) step();

      // Reset on beat 2 of a 5-beat frame
      b.data = 64'hA1; b.keep = '1; b.last = 1'b0; b.user = '0;
      fbeat(b, 1);
      s_tdata = 64'hA2; s_tvalid = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; s_tvalid = 1'b0;
      @(negedge clk);
      chk("midrst_m_tvalid", m_tvalid, 0);
      chk("midrst_occ", occ, 0);
      chk("midrst_ready", s_tready, 1);
      step();
      send_frame(2, 0, 0, 1, 64'h500);
      repeat (8) step();
      chk("midrst_next_frame", exp_q.size(), 0);
      chk("midrst_occ_end", occ, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: tdata width in bits, multiple of 8.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: tkeep width.
REQ-003 SHALL have parameter DEPTH, default 512: storage entries, power of two, min 4.
REQ-004 SHALL have parameter USER_WIDTH, default 1: tuser width; tuser[0] is the bad-frame flag.
REQ-005 SHALL have parameter FRAME_FIFO, default 1: 1 = store-and-forward with frame drop, 0 = plain word FIFO.
REQ-006 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port s_axis_tdata  in  DATA_WIDTH  input data.
REQ-009 SHALL have port s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
REQ-010 SHALL have port s_axis_tvalid  in  1  input beat valid.
REQ-011 SHALL have port s_axis_tready  out  1  input beat accepted when high with tvalid.
REQ-012 SHALL have port s_axis_tlast  in  1  last beat of frame.
REQ-013 SHALL have port s_axis_tuser  in  USER_WIDTH  sideband, stored with beat.
REQ-014 SHALL have port m_axis_tdata  out  DATA_WIDTH  output data.
REQ-015 SHALL have port m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
REQ-016 SHALL have port m_axis_tvalid  out  1  output beat valid.
REQ-017 SHALL have port m_axis_tready  in  1  downstream accepts beat.
REQ-018 SHALL have port m_axis_tlast  out  1  last beat of frame.
REQ-019 SHALL have port m_axis_tuser  out  USER_WIDTH  sideband.
REQ-020 SHALL have port occupancy  out  log2(DEPTH)+1  committed words in storage (wr_commit - rd_ptr).
REQ-021 SHALL have port status_overflow  out  1  one-cycle pulse per frame dropped for lack of space.
REQ-022 SHALL have port status_bad_frame  out  1  one-cycle pulse per frame dropped for tuser[0]=1 on tlast.

Function
REQ-023 SHALL store {tdata,tkeep,tlast,tuser} per accepted beat; pointers log2(DEPTH)+1 bits, extra MSB wraps to distinguish full (MSB differs, rest equal) from empty (equal).
REQ-024 FRAME_FIFO=0: s_axis_tready = !full, registered decision; write while full rejected even if a read occurs same cycle; every accepted beat committed immediately; tuser ignored for dropping.
REQ-025 FRAME_FIFO=1: s_axis_tready = 1 except during rst; write FSM states WR_IDLE, WR_FRAME, WR_DROP.
REQ-026 WR_IDLE/WR_FRAME: beat written at wr_cur, wr_cur++; on tlast with tuser[0]=0 -> wr_commit=wr_cur+1, go WR_IDLE; tlast with tuser[0]=1 -> wr_cur rewinds to wr_commit, status_bad_frame pulse, go WR_IDLE.
REQ-027 Accepted beat while wr_cur-rd_ptr=DEPTH (incl. frames longer than DEPTH) -> wr_cur rewinds to wr_commit, go WR_DROP (or WR_IDLE with status_overflow if that beat has tlast).
REQ-028 WR_DROP: beats discarded; on tlast -> status_overflow pulse, go WR_IDLE; bad flag ignored there (overflow only).
REQ-029 Read side reads only committed entries (rd_ptr != wr_commit); RAM read register plus output register; m_axis_tvalid rises 2 cycles after commit of first entry into empty FIFO (FRAME_FIFO=1: 2 cycles after tlast beat accepted).
REQ-030 Output SHALL sustain one beat/cycle with m_axis_tready=1; while tvalid && !tready all m_axis_* held stable; m_axis_tdata not zeroed when invalid.
REQ-031 Simultaneous commit and read SHALL update occupancy by net difference in one cycle.

Reset
REQ-032 rst SHALL clear rd_ptr, wr_cur, wr_commit, FSM to WR_IDLE, pipeline valids; m_axis_tvalid=0, occupancy=0, status pulses=0, s_axis_tready=0 during rst and =1 first cycle after (FRAME_FIFO=1) or =!full (FRAME_FIFO=0).
REQ-033 rst mid-frame SHALL discard the partial frame and all stored data; storage RAM contents need not be cleared.

Structure
REQ-034 Shared package SHALL hold FSM state encodings and field-offset localparams for the packed storage word; ADDR_WIDTH derived locally via $clog2(DEPTH).
REQ-035 One sub-module SHALL be used: axis_pkt_fifo_ram, simple dual-port, one write and one registered read port on clk.

Verification (DEPTH=16, DATA_WIDTH=64, FRAME_FIFO=1 unless noted)
REQ-036 Good 4-beat frame, data 0x1..0x4, tready=1 -> output 4 contiguous beats, tlast on 0x4, tvalid first 2 cycles after input tlast, occupancy peaks 4.
REQ-037 3-beat frame with tuser[0]=1 on tlast -> no output, status_bad_frame one pulse, occupancy 0, next good frame passes intact.
REQ-038 20-beat frame -> dropped, status_overflow one pulse on beat 20, s_axis_tready=1 throughout, occupancy 0.
REQ-039 FRAME_FIFO=0, tready=0, 17 beats offered -> 16 accepted, s_axis_tready=0 at full; then tready=1 -> beats 1..16 in order, no loss.
REQ-040 Random tready backpressure over 100 frames -> output held stable while stalled, data matches scoreboard, no duplicates.
REQ-041 rst asserted on beat 2 of 5-beat frame -> m_axis_tvalid=0, occupancy=0; following 2-beat frame delivered exactly.
